coin_encoder: RTL and testbench

- Sits between the optical coin gate and the vending FSM; produces the FSM's `coin_in` code.
- Synchronises the raw, asynchronous beam-break signal and measures how long each coin blocks the beam.
- Classifies that width as a 5 rs coin, a 10 rs coin or a reject, and emits a one-cycle code: 01 = 5, 10 = 10, 00 = idle.
- Also flags jammed coins and enforces a hold-off gap between coins.

---
 rtl/coin_encoder.sv | 136 +++++++++++++
 tb/tb_coin_encoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_encoder.sv
// coin_encoder: turns the optical coin-gate beam-break signal into one-cycle
// coin codes for the vending FSM (01 = 5 rs, 10 = 10 rs) or a reject pulse,
// with jam detection and a quiet-gap hold-off between coins.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a fresh rising edge of the synchronised beam
// MEASURE  | beam blocked, counting high width
// HOLDOFF  | coin classified, waiting for HOLDOFF quiet cycles
// JAM      | beam blocked too long, waiting for HOLDOFF quiet cycles
module coin_encoder #(
  parameter int CNT_W     = 8,
  parameter int MIN5      = 20,
  parameter int MAX5      = 40,
  parameter int MIN10     = 60,
  parameter int MAX10     = 100,
  parameter int JAM_LIMIT = 200,
  parameter int HOLDOFF   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_sense,
  input  logic       accept_en,
  output logic [1:0] coin_out,
  output logic       reject,
  output logic       jam,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_HOLDOFF, S_JAM} state_t;

  localparam logic [CNT_W-1:0] MIN5_C      = CNT_W'(MIN5);
  localparam logic [CNT_W-1:0] MAX5_C      = CNT_W'(MAX5);
  localparam logic [CNT_W-1:0] MIN10_C     = CNT_W'(MIN10);
  localparam logic [CNT_W-1:0] MAX10_C     = CNT_W'(MAX10);
  localparam logic [CNT_W-1:0] JAM_C       = CNT_W'(JAM_LIMIT);
  localparam logic [CNT_W-1:0] HOLD_LAST_C = CNT_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       coin_out_q;
  logic             reject_q;

  logic       s1_q;
  logic       s_q;
  logic       s_dly_q;
  logic [1:0] vld_q;
  logic       armed_q;
  logic       rise;
  logic       in5;
  logic       in10;

  // Two-flop synchroniser plus delayed copy. armed_q only sets once a genuine
  // (post-reset) low has been seen, so a beam already blocked when reset
  // releases cannot look like a fresh rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= coin_sense;
      s_q     <= s1_q;
      s_dly_q <= s_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & ~s_q);
    end
  end

  assign rise    = armed_q & s_q & ~s_dly_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ONE_C;
  assign in5     = (cnt_q >= MIN5_C) && (cnt_q <= MAX5_C);
  assign in10    = (cnt_q >= MIN10_C) && (cnt_q <= MAX10_C);

  // Sequencer: width measurement, classification, jam and hold-off handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      coin_out_q <= 2'b00;
      reject_q   <= 1'b0;
    end else begin
      coin_out_q <= 2'b00;
      reject_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_q <= S_MEASURE;
            cnt_q   <= ONE_C;
          end
        end
        S_MEASURE: begin
          if (s_q) begin
            if (cnt_q == JAM_C) begin
              state_q  <= S_JAM;
              reject_q <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end else begin
            if (accept_en && in5)       coin_out_q <= 2'b01;
            else if (accept_en && in10) coin_out_q <= 2'b10;
            else                        reject_q   <= 1'b1;
            state_q <= S_HOLDOFF;
            cnt_q   <= '0;
          end
        end
        S_HOLDOFF, S_JAM: begin
          if (s_q) begin
            cnt_q <= '0;
          end else if (cnt_q == HOLD_LAST_C) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign coin_out = coin_out_q;
  assign reject   = reject_q;
  assign jam      = (state_q == S_JAM);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_coin_encoder.sv
// Directed bench for coin_encoder: coin classification, boundaries, jam,
// hold-off swallowing and reset in mid-measurement.
module tb_coin_encoder;

  logic       clk;
  logic       rst_n;
  logic       coin_sense;
  logic       accept_en;
  logic [1:0] coin_out;
  logic       reject;
  logic       jam;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int n5 = 0, n10 = 0, nrej = 0, nbad = 0;

  coin_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coin_sense(coin_sense),
    .accept_en (accept_en),
    .coin_out  (coin_out),
    .reject    (reject),
    .jam       (jam),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event tally sampled away from the active edge.
  always @(negedge clk) begin
    if (coin_out == 2'b01 && !reject) n5++;
    if (coin_out == 2'b10 && !reject) n10++;
    if (reject && coin_out == 2'b00) nrej++;
    if (coin_out == 2'b11 || (reject && coin_out != 2'b00)) nbad++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pulse(input int w);
    @(negedge clk);
    coin_sense = 1'b1;
    repeat (w) @(negedge clk);
    coin_sense = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    coin_sense = 1'b0;
    accept_en = 1'b1;
    idle(3);
    checks++;
    if (coin_out !== 2'b00) begin errors++; $display("FAIL reset_coin_out: got %b want 00", coin_out); end
    checks++;
    if (reject !== 1'b0) begin errors++; $display("FAIL reset_reject: got %b want 0", reject); end
    checks++;
    if (jam !== 1'b0) begin errors++; $display("FAIL reset_jam: got %b want 0", jam); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_single_coin;
    logic [1:0] exp_code;
    accept_en = 1'b1;
    send_pulse(30);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      exp_code = (k == 3) ? 2'b01 : 2'b00;
      checks++;
      if (coin_out !== exp_code) begin
        errors++;
        $display("FAIL single_coin_out k=%0d: got %b want %b", k, coin_out, exp_code);
      end
      checks++;
      if (reject !== 1'b0) begin
        errors++;
        $display("FAIL single_reject k=%0d: got %b want 0", k, reject);
      end
      if (k == 18) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_held: got %b want 1", busy); end
      end
      if (k == 19) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b want 0", busy); end
      end
    end
    idle(3);
  endtask

  task automatic test_widths;
    int w_tab[10]   = '{19, 20, 40, 41, 59, 60, 100, 101, 1, 200};
    int exp_tab[10] = '{0,  1,  1,  0,  0,  2,  2,   0,   0, 0};
    int b5, b10, br;
    accept_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b5 = n5; b10 = n10; br = nrej;
      send_pulse(w_tab[i]);
      idle(25);
      checks++;
      if ((n5 - b5) !== ((exp_tab[i] == 1) ? 1 : 0)) begin
        errors++; $display("FAIL width_%0d_five: got %0d want %0d", w_tab[i], n5 - b5, (exp_tab[i] == 1) ? 1 : 0);
      end
      checks++;
      if ((n10 - b10) !== ((exp_tab[i] == 2) ? 1 : 0)) begin
        errors++; $display("FAIL width_%0d_ten: got %0d want %0d", w_tab[i], n10 - b10, (exp_tab[i] == 2) ? 1 : 0);
      end
      checks++;
      if ((nrej - br) !== ((exp_tab[i] == 0) ? 1 : 0)) begin
        errors++; $display("FAIL width_%0d_reject: got %0d want %0d", w_tab[i], nrej - br, (exp_tab[i] == 0) ? 1 : 0);
      end
      checks++;
      if (jam !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL width_%0d_settle: jam=%b busy=%b want 0 0", w_tab[i], jam, busy);
      end
    end
  endtask

  task automatic test_accept_disabled;
    int b5, b10, br;
    b5 = n5; b10 = n10; br = nrej;
    accept_en = 1'b0;
    send_pulse(80);
    idle(25);
    accept_en = 1'b1;
    checks++;
    if ((n5 - b5) + (n10 - b10) !== 0) begin
      errors++; $display("FAIL accept_dis_coin: got %0d coins want 0", (n5 - b5) + (n10 - b10));
    end
    checks++;
    if ((nrej - br) !== 1) begin
      errors++; $display("FAIL accept_dis_reject: got %0d want 1", nrej - br);
    end
  endtask

  task automatic test_jam;
    int b5, b10, br;
    b5 = n5; b10 = n10; br = nrej;
    @(negedge clk);
    coin_sense = 1'b1;
    repeat (250) @(negedge clk);
    checks++;
    if (jam !== 1'b1) begin errors++; $display("FAIL jam_asserted: got %b want 1", jam); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL jam_busy: got %b want 1", busy); end
    repeat (50) @(negedge clk);
    coin_sense = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 17) begin
        checks++;
        if (jam !== 1'b1) begin errors++; $display("FAIL jam_held: got %b want 1", jam); end
      end
      if (k == 18) begin
        checks++;
        if (jam !== 1'b0) begin errors++; $display("FAIL jam_cleared: got %b want 0", jam); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL jam_busy_cleared: got %b want 0", busy); end
      end
    end
    idle(5);
    checks++;
    if ((nrej - br) !== 1) begin errors++; $display("FAIL jam_reject_count: got %0d want 1", nrej - br); end
    checks++;
    if ((n5 - b5) + (n10 - b10) !== 0) begin
      errors++; $display("FAIL jam_no_coin: got %0d want 0", (n5 - b5) + (n10 - b10));
    end
  endtask

  task automatic test_back_to_back;
    int b5, br;
    accept_en = 1'b1;
    b5 = n5; br = nrej;
    send_pulse(30);
    idle(4);
    send_pulse(30);
    idle(29);
    checks++;
    if ((n5 - b5) !== 1) begin errors++; $display("FAIL b2b_swallowed: got %0d want 1", n5 - b5); end
    send_pulse(30);
    idle(25);
    checks++;
    if ((n5 - b5) !== 2) begin errors++; $display("FAIL b2b_second_coin: got %0d want 2", n5 - b5); end
    checks++;
    if ((nrej - br) !== 0) begin errors++; $display("FAIL b2b_reject: got %0d want 0", nrej - br); end
  endtask

  task automatic test_reset_mid;
    int b5, b10, br;
    accept_en = 1'b1;
    b5 = n5; b10 = n10; br = nrej;
    @(negedge clk);
    coin_sense = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || jam !== 1'b0 || reject !== 1'b0 || coin_out !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_outputs: busy=%b jam=%b reject=%b coin=%b want 0 0 0 00", busy, jam, reject, coin_out);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    coin_sense = 1'b0;
    idle(25);
    checks++;
    if ((n5 - b5) + (n10 - b10) + (nrej - br) !== 0) begin
      errors++; $display("FAIL rstmid_no_event: got %0d events want 0", (n5 - b5) + (n10 - b10) + (nrej - br));
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
    send_pulse(30);
    idle(25);
    checks++;
    if ((n5 - b5) !== 1) begin errors++; $display("FAIL rstmid_next_coin: got %0d want 1", n5 - b5); end
  endtask

  initial begin
    coin_sense = 1'b0;
    accept_en  = 1'b1;
    rst_n      = 1'b0;
    test_reset();
    test_single_coin();
    test_widths();
    test_accept_disabled();
    test_jam();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (nbad !== 0) begin errors++; $display("FAIL illegal_output: got %0d illegal cycles want 0", nbad); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
